uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmit path.
- Accepts THR byte writes from the register interface and buffers them in a 1/16/64-entry FIFO selected by FCR mode.
- Holds the byte being serialised stable in a transmit shift register (TSR) and drives TXSTART/DIN of uart_transmitter, using its TXFINISHED pulse as the frame-done handshake.
- Implements 16750 automatic CTS flow control and produces the THRE/TEMT status used by the LSR and interrupt logic.

Parameters:
- MAX_DEPTH, 64, physical FIFO entries; power of two, ≥16.
- AW, $clog2(MAX_DEPTH), FIFO pointer width.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- WR  in  1  one-cycle THR write strobe
- WDATA  in  8  THR write data
- FIFOEN  in  1  FCR[0]: 0 = single holding register (depth 1)
- FIFO64  in  1  FCR[5]: 1 = depth 64, 0 = depth 16 (only when FIFOEN=1)
- TXCLEAR  in  1  one-cycle FCR[2] TX FIFO reset
- AFE  in  1  MCR automatic flow control enable
- CTS_N  in  1  clear-to-send, already synchronised, active low
- TXFINISHED  in  1  one-cycle pulse from transmitter on entering STOP
- TXSTART  out  1  request to transmitter
- DOUT  out  8  TSR contents, to transmitter DIN
- THRE  out  1  holding register / FIFO empty
- TEMT  out  1  FIFO empty and no frame in flight
- THRI  out  1  one-cycle pulse: FIFO became empty by a pop
- USAGE  out  AW+1  current FIFO occupancy

Behaviour:
- Reset values: TXSTART=0, DOUT=8'h00, THRE=1, TEMT=1, THRI=0, USAGE=0, state IDLE, pointers 0.
- Effective depth:
  - FIFOEN=0 → 1.
  - FIFOEN=1, FIFO64=0 → 16.
  - FIFOEN=1, FIFO64=1 → 64.
- Full when USAGE == effective depth.
- Write path:
  - WR with USAGE < depth: push WDATA; USAGE +1 next cycle.
  - WR when full: ignored, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: USAGE unchanged.
- Flush: TXCLEAR, or any change of FIFOEN/FIFO64 versus its previous-cycle value, clears the FIFO next cycle (USAGE=0, pointers 0).
  - Flush overrides a same-cycle WR and pop.
  - TSR and any frame in flight are unaffected.
- FSM states: IDLE, LOAD, BUSY.
- IDLE: TXSTART=0.
  - If USAGE>0 and not blocked → pop head into DOUT, go LOAD.
  - Blocked means AFE=1 and CTS_N=1.
- LOAD: TXSTART=1, go BUSY next cycle.
- BUSY: TXSTART held 1; DOUT held stable for the whole frame. On TXFINISHED:
  - If USAGE>0 and not blocked: pop into DOUT in that same cycle and stay BUSY with TXSTART=1. This gives a back-to-back frame from STOP/STOP2 with no IDLE gap.
  - Otherwise: TXSTART=0 next cycle, go IDLE.
- Latency: WR into an empty FIFO with FSM in IDLE (cycle N) → USAGE=1 at N+1, pop at N+1, TXSTART=1 at N+2.
- Flow control: CTS_N is sampled only at pop decisions, so a frame in progress always completes. Deasserting CTS_N releases IDLE on the next cycle.
- THRE = (USAGE==0), registered.
- THRI pulses one cycle when a pop takes USAGE from 1 to 0. It does not pulse on a flush.
- TEMT:
  - Cleared on any push.
  - Set in the cycle after the FSM enters IDLE with USAGE==0.
  - Note: TEMT does not wait for the stop bit(s) to drain. This is accepted.
- Transmitter constraint: the TXCLK step interval must be ≥4 CLK cycles. This guarantees TXSTART is updated before the transmitter leaves STOP.
- A sync reset mid-frame returns all state to reset values immediately. The transmitter has its own reset.

Decomposition:
- Shared package uart_pkg holds:
  - the feeder state enum (IDLE, LOAD, BUSY);
  - the depth constants DEPTH_NOFIFO=1, DEPTH_16=16, DEPTH_64=64.
- Sub-module uart_sync_fifo: generic 8-bit synchronous FIFO with push, pop, flush, a runtime depth limit input, USAGE/empty/full outputs, and head data valid while not empty.
- The feeder keeps only the FSM, TSR and status logic.

Test Plan:
- Reset, FIFOEN=1, FIFO64=0, write 8'hA5 at cycle 0 → TXSTART=1 at cycle 2, DOUT=8'hA5, THRE returns 1, THRI pulses once; after TXFINISHED: TXSTART=0, IDLE, TEMT=1.
- Write 8'h11, 8'h22, 8'h33 back-to-back → three frames in order; TXSTART never drops between frames; DOUT changes only in the cycle after each TXFINISHED.
- FIFO64=0: hold the transmitter stalled, write 20 bytes → USAGE saturates at 16, bytes 17–20 dropped; set FIFO64=1 → FIFO flushed, USAGE=0, in-flight DOUT unchanged.
- AFE=1, CTS_N=1, write 8'h5A → TXSTART stays 0, USAGE=1; drop CTS_N → TXSTART=1 within 2 cycles. Raising CTS_N mid-frame does not drop TXSTART before TXFINISHED.
- FIFOEN=0: write 8'h01 then 8'h02 while the TSR is busy → second write accepted only after the first is popped into the TSR; third write while full ignored.
- Assert RST while BUSY with USAGE=5 → next cycle TXSTART=0, USAGE=0, THRE=1, TEMT=1, DOUT=8'h00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: feeder states and FIFO depth modes.
package uart_pkg;

   // Feeder sequencing: wait for data, present a new byte, hold it through the frame.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2
   } feeder_state_e;

   localparam int unsigned DEPTH_NOFIFO = 1;
   localparam int unsigned DEPTH_16     = 16;
   localparam int unsigned DEPTH_64     = 64;

   // Effective transmit FIFO depth for an FCR mode (FCR[0] enable, FCR[5] 64-byte mode).
   function automatic int unsigned fifo_depth(input logic fifoen, input logic fifo64);
      if (!fifoen) begin
         return DEPTH_NOFIFO;
      end
      return fifo64 ? DEPTH_64 : DEPTH_16;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic 8-bit synchronous FIFO with a runtime depth limit and a flush that clears it.
// Storage is always MAX_DEPTH entries; the limit only moves the "full" threshold.
module uart_sync_fifo #(
   parameter int unsigned MAX_DEPTH = 64,
   parameter int unsigned AW        = $clog2(MAX_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   input  logic          flush,
   input  logic [AW:0]   depth_limit,
   output logic [7:0]    rdata,
   output logic [AW:0]   usage,
   output logic          empty,
   output logic          full
);

   logic [7:0]    mem [MAX_DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   usage_q;
   logic          push_ok;
   logic          pop_ok;

   assign empty = (usage_q == '0);
   // Full is judged on the pre-edge occupancy, so a write at full is lost even with a pop.
   assign full  = (usage_q >= depth_limit);

   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   assign rdata = mem[rptr_q];
   assign usage = usage_q;

   // Pointer and occupancy bookkeeping; a flush wins over any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usage_q <= '0;
      end else begin
         if (push_ok) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop_ok) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   usage_q <= usage_q + 1'b1;
            2'b01:   usage_q <= usage_q - 1'b1;
            default: usage_q <= usage_q;
         endcase
      end
   end

   // Data storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit feeder: buffers THR writes, hands bytes to the transmitter through the TSR,
// applies automatic CTS flow control and derives THRE/TEMT/THRI status.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int unsigned MAX_DEPTH = 64,
   parameter int unsigned AW        = $clog2(MAX_DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WR,
   input  logic [7:0]    WDATA,
   input  logic          FIFOEN,
   input  logic          FIFO64,
   input  logic          TXCLEAR,
   input  logic          AFE,
   input  logic          CTS_N,
   input  logic          TXFINISHED,
   output logic          TXSTART,
   output logic [7:0]    DOUT,
   output logic          THRE,
   output logic          TEMT,
   output logic          THRI,
   output logic [AW:0]   USAGE
);

   localparam int unsigned UW = AW + 1;

   feeder_state_e state_q;
   logic          txstart_q;
   logic [7:0]    dout_q;
   logic          temt_q;
   logic          thri_q;
   logic          fifoen_q;
   logic          fifo64_q;

   int unsigned   depth_req;
   logic [AW:0]   depth_limit;
   logic          flush;
   logic          blocked;
   logic          pop_slot;
   logic          pop;
   logic          push_ok;
   logic [7:0]    head;
   logic [AW:0]   usage;
   logic          empty;
   logic          full;

   // Depth limit for the current FCR mode, clamped to the physical storage.
   always_comb begin
      depth_req = fifo_depth(FIFOEN, FIFO64);
      if (depth_req > MAX_DEPTH) begin
         depth_req = MAX_DEPTH;
      end
      depth_limit = UW'(depth_req);
   end

   // Any FCR mode change invalidates the buffered bytes, same as an explicit TX clear.
   assign flush   = TXCLEAR || (FIFOEN != fifoen_q) || (FIFO64 != fifo64_q);
   assign blocked = AFE && CTS_N;
   // CTS is only consulted where a new byte could be taken, so frames never get cut short.
   assign pop_slot = (state_q == IDLE) || ((state_q == BUSY) && TXFINISHED);
   assign pop      = pop_slot && !empty && !blocked && !flush;
   assign push_ok  = WR && !full && !flush;

   uart_sync_fifo #(
      .MAX_DEPTH (MAX_DEPTH),
      .AW        (AW)
   ) u_fifo (
      .clk         (CLK),
      .rst         (RST),
      .push        (WR),
      .wdata       (WDATA),
      .pop         (pop),
      .flush       (flush),
      .depth_limit (depth_limit),
      .rdata       (head),
      .usage       (usage),
      .empty       (empty),
      .full        (full)
   );

   // Remember the FCR mode bits so a change can be detected; captured through reset too.
   always_ff @(posedge CLK) begin
      fifoen_q <= FIFOEN;
      fifo64_q <= FIFO64;
   end

   // Feeder FSM with registered TXSTART and TSR.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         txstart_q <= 1'b0;
         dout_q    <= 8'h00;
      end else begin
         unique case (state_q)
            IDLE: begin
               txstart_q <= 1'b0;
               if (pop) begin
                  dout_q    <= head;
                  txstart_q <= 1'b1;
                  state_q   <= LOAD;
               end
            end
            LOAD: begin
               txstart_q <= 1'b1;
               state_q   <= BUSY;
            end
            BUSY: begin
               if (TXFINISHED) begin
                  if (pop) begin
                     // Reload during STOP so the transmitter chains the next frame.
                     dout_q <= head;
                  end else begin
                     txstart_q <= 1'b0;
                     state_q   <= IDLE;
                  end
               end
            end
            default: begin
               txstart_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   // Status flags: THRI marks the pop that drains the FIFO, TEMT tracks an idle empty path.
   always_ff @(posedge CLK) begin
      if (RST) begin
         temt_q <= 1'b1;
         thri_q <= 1'b0;
      end else begin
         thri_q <= pop && (usage == UW'(1)) && !push_ok;
         if (push_ok) begin
            temt_q <= 1'b0;
         end else if ((state_q == IDLE) && empty) begin
            temt_q <= 1'b1;
         end
      end
   end

   assign TXSTART = txstart_q;
   assign DOUT    = dout_q;
   assign THRE    = empty;
   assign TEMT    = temt_q;
   assign THRI    = thri_q;
   assign USAGE   = usage;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model compared every cycle,
// a transmitter stand-in producing TXFINISHED, directed scenarios, then random traffic.
module tb_uart_tx_feeder;

   localparam int unsigned MAX_DEPTH = 64;
   localparam int unsigned AW        = $clog2(MAX_DEPTH);
   localparam int PH_IDLE = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_BUSY = 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic          WR;
   logic [7:0]    WDATA;
   logic          FIFOEN;
   logic          FIFO64;
   logic          TXCLEAR;
   logic          AFE;
   logic          CTS_N;
   logic          TXFINISHED;
   logic          TXSTART;
   logic [7:0]    DOUT;
   logic          THRE;
   logic          TEMT;
   logic          THRI;
   logic [AW:0]   USAGE;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   uart_tx_feeder #(
      .MAX_DEPTH (MAX_DEPTH),
      .AW        (AW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .WR         (WR),
      .WDATA      (WDATA),
      .FIFOEN     (FIFOEN),
      .FIFO64     (FIFO64),
      .TXCLEAR    (TXCLEAR),
      .AFE        (AFE),
      .CTS_N      (CTS_N),
      .TXFINISHED (TXFINISHED),
      .TXSTART    (TXSTART),
      .DOUT       (DOUT),
      .THRE       (THRE),
      .TEMT       (TEMT),
      .THRI       (THRI),
      .USAGE      (USAGE)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   byte unsigned m_q[$];      // bytes waiting in the FIFO
   byte unsigned m_sent[$];   // bytes handed to the transmitter, not yet finished
   int           m_phase = PH_IDLE;
   logic         m_txstart = 1'b0;
   logic [7:0]   m_dout = 8'h00;
   logic         m_temt = 1'b1;
   logic         m_thri = 1'b0;
   logic         m_en_prev = 1'b0;
   logic         m_64_prev = 1'b0;
   bit           model_live = 1'b0;

   function automatic int depth_of(input logic en, input logic f64);
      if (!en) return 1;
      return f64 ? 64 : 16;
   endfunction

   task automatic model_step();
      int usage;
      int old_phase;
      bit flush;
      bit can_pop;
      bit do_pop;
      bit do_push;
      if (RST) begin
         m_q.delete();
         m_sent.delete();
         m_phase    = PH_IDLE;
         m_txstart  = 1'b0;
         m_dout     = 8'h00;
         m_temt     = 1'b1;
         m_thri     = 1'b0;
         model_live = 1'b1;
      end else begin
         usage     = m_q.size();
         old_phase = m_phase;
         flush     = TXCLEAR || (FIFOEN !== m_en_prev) || (FIFO64 !== m_64_prev);
         can_pop   = !flush && usage > 0 && !(AFE && CTS_N);
         do_push   = WR && usage < depth_of(FIFOEN, FIFO64) && !flush;
         do_pop    = 1'b0;
         case (m_phase)
            PH_IDLE: begin
               m_txstart = can_pop;
               if (can_pop) begin
                  do_pop  = 1'b1;
                  m_phase = PH_LOAD;
               end
            end
            PH_LOAD: begin
               m_txstart = 1'b1;
               m_phase   = PH_BUSY;
            end
            default: begin
               if (TXFINISHED) begin
                  if (can_pop) begin
                     do_pop = 1'b1;
                  end else begin
                     m_txstart = 1'b0;
                     m_phase   = PH_IDLE;
                  end
               end
            end
         endcase
         m_thri = do_pop && usage == 1 && !do_push;
         if (do_push) m_temt = 1'b0;
         else if (old_phase == PH_IDLE && usage == 0) m_temt = 1'b1;
         if (flush) begin
            m_q.delete();
         end else begin
            if (do_pop) begin
               m_dout = m_q.pop_front();
               m_sent.push_back(m_dout);
            end
            if (do_push) m_q.push_back(WDATA);
         end
      end
      m_en_prev = FIFOEN;
      m_64_prev = FIFO64;
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         model_step();
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge CLK);
         if (model_live) begin
            chk("cmp_txstart", TXSTART, m_txstart);
            chk("cmp_dout", DOUT, m_dout);
            chk("cmp_thre", THRE, m_q.size() == 0);
            chk("cmp_temt", TEMT, m_temt);
            chk("cmp_thri", THRI, m_thri);
            chk("cmp_usage", USAGE, m_q.size());
         end
      end
   end

   // ---------------- transmitter stand-in ----------------
   bit         stall = 1'b0;
   bit         rand_len = 1'b0;
   int         tx_ph = 0;
   int         tx_cnt = 0;
   logic [7:0] tx_byte = 8'h00;
   int         rx_count = 0;
   logic [7:0] rx_log[$];

   initial begin
      TXFINISHED = 1'b0;
      forever begin
         @(negedge CLK);
         #1;
         TXFINISHED = 1'b0;
         if (RST) begin
            tx_ph = 0;
         end else begin
            case (tx_ph)
               0: begin
                  if (TXSTART === 1'b1) begin
                     tx_byte = DOUT;
                     tx_cnt  = rand_len ? int'($urandom_range(4, 10)) : 6;
                     tx_ph   = 1;
                  end
               end
               1: begin
                  chk("dout_stable", DOUT, tx_byte);
                  if (!stall) begin
                     tx_cnt--;
                     if (tx_cnt <= 0) begin
                        TXFINISHED = 1'b1;
                        rx_log.push_back(tx_byte);
                        rx_count++;
                        if (m_sent.size() == 0) chk("frame_pending", m_sent.size(), 1);
                        else chk("frame_order", tx_byte, m_sent.pop_front());
                        tx_ph  = 2;
                        tx_cnt = 4;
                     end
                  end
               end
               default: begin
                  tx_cnt--;
                  if (tx_cnt <= 0) tx_ph = 0;
               end
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge CLK);
   endtask

   task automatic write(input logic [7:0] d);
      WR    = 1'b1;
      WDATA = d;
      tick();
      WR    = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(TXSTART === 1'b0 && TEMT === 1'b1 && USAGE === '0) && n < 500) begin
         tick();
         n++;
      end
      chk(name, n < 500, 1);
   endtask

   int  base;
   int  n;
   bit  seen;
   bit  dropped;

   initial begin
      RST = 1'b1; WR = 1'b0; WDATA = 8'h00; FIFOEN = 1'b1; FIFO64 = 1'b0;
      TXCLEAR = 1'b0; AFE = 1'b0; CTS_N = 1'b0;
      tick(3);
      chk("rst_txstart", TXSTART, 0);
      chk("rst_dout", DOUT, 8'h00);
      chk("rst_thre", THRE, 1);
      chk("rst_temt", TEMT, 1);
      chk("rst_thri", THRI, 0);
      chk("rst_usage", USAGE, 0);
      RST = 1'b0;
      tick(2);

      // Single byte latency and status.
      write(8'hA5);
      chk("t1_usage", USAGE, 1);
      chk("t1_start_early", TXSTART, 0);
      chk("t1_temt_clear", TEMT, 0);
      tick();
      chk("t1_txstart", TXSTART, 1);
      chk("t1_dout", DOUT, 8'hA5);
      chk("t1_thre", THRE, 1);
      chk("t1_thri", THRI, 1);
      tick();
      chk("t1_thri_once", THRI, 0);
      wait_idle("t1_idle");
      chk("t1_rx", rx_log[rx_log.size() - 1], 8'hA5);

      // Back-to-back frames without a TXSTART gap.
      base = rx_count; seen = 0; dropped = 0; n = 0;
      write(8'h11); write(8'h22); write(8'h33);
      while (rx_count < base + 3 && n < 300) begin
         if (TXSTART === 1'b1) seen = 1;
         else if (seen) dropped = 1;
         tick();
         n++;
      end
      chk("t2_frames", rx_count - base, 3);
      chk("t2_no_gap", dropped, 0);
      chk("t2_b0", rx_log[base], 8'h11);
      chk("t2_b1", rx_log[base + 1], 8'h22);
      chk("t2_b2", rx_log[base + 2], 8'h33);
      wait_idle("t2_idle");

      // Saturation at 16, then a mode change flushes without touching the TSR.
      stall = 1'b1;
      write(8'h40);
      tick(3);
      for (int i = 0; i < 20; i++) write(8'(8'h41 + i));
      chk("t3_usage_sat", USAGE, 16);
      FIFO64 = 1'b1;
      tick();
      chk("t3_flushed", USAGE, 0);
      chk("t3_thre", THRE, 1);
      chk("t3_dout_kept", DOUT, 8'h40);
      chk("t3_txstart_kept", TXSTART, 1);
      base = rx_count;
      stall = 1'b0;
      wait_idle("t3_idle");
      chk("t3_frames", rx_count - base, 1);

      // CTS flow control.
      AFE = 1'b1; CTS_N = 1'b1;
      write(8'h5A);
      tick(4);
      chk("t4_blocked_start", TXSTART, 0);
      chk("t4_blocked_usage", USAGE, 1);
      CTS_N = 1'b0;
      tick();
      chk("t4_release", TXSTART, 1);
      CTS_N = 1'b1;
      base = rx_count; dropped = 0; n = 0;
      while (rx_count == base && n < 200) begin
         if (TXSTART !== 1'b1) dropped = 1;
         tick();
         n++;
      end
      chk("t4_frame_done", rx_count - base, 1);
      chk("t4_no_abort", dropped, 0);
      chk("t4_rx", rx_log[base], 8'h5A);
      AFE = 1'b0; CTS_N = 1'b0;
      wait_idle("t4_idle");

      // Single holding register mode.
      FIFOEN = 1'b0;
      tick(2);
      stall = 1'b1;
      base = rx_count;
      write(8'h01);
      write(8'h02);
      chk("t5_full_with_pop", USAGE, 0);
      write(8'h03);
      chk("t5_second", USAGE, 1);
      write(8'h04);
      chk("t5_full_drop", USAGE, 1);
      chk("t5_tsr", DOUT, 8'h01);
      stall = 1'b0;
      wait_idle("t5_idle");
      chk("t5_frames", rx_count - base, 2);
      chk("t5_b0", rx_log[base], 8'h01);
      chk("t5_b1", rx_log[base + 1], 8'h03);

      // Reset in the middle of a frame with bytes queued.
      FIFOEN = 1'b1;
      tick(2);
      stall = 1'b1;
      write(8'h70);
      tick(3);
      for (int i = 0; i < 5; i++) write(8'(8'h71 + i));
      chk("t6_usage", USAGE, 5);
      RST = 1'b1;
      tick();
      chk("t6_txstart", TXSTART, 0);
      chk("t6_usage_rst", USAGE, 0);
      chk("t6_thre", THRE, 1);
      chk("t6_temt", TEMT, 1);
      chk("t6_dout", DOUT, 8'h00);
      RST = 1'b0;
      stall = 1'b0;
      tick(2);

      // Random traffic against the model.
      rand_len = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         WR      = ($urandom_range(0, 99) < 40);
         WDATA   = 8'($urandom);
         TXCLEAR = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 299) == 0) FIFOEN = ~FIFOEN;
         if ($urandom_range(0, 299) == 0) FIFO64 = ~FIFO64;
         if ($urandom_range(0, 99) == 0) AFE = ~AFE;
         if ($urandom_range(0, 19) == 0) CTS_N = ~CTS_N;
         if ($urandom_range(0, 99) < 8) stall = ~stall;
         RST     = ($urandom_range(0, 999) == 0);
         tick();
      end
      WR = 1'b0; TXCLEAR = 1'b0; AFE = 1'b0; CTS_N = 1'b0; RST = 1'b0; stall = 1'b0;
      wait_idle("rand_drain");
      tick(6);
      chk("rand_all_sent", m_sent.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
